// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, line geometry and the line-fetch state enum.
package ahb_pkg;

  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BURST = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/ahb_wrap_addr.sv
// WRAP4 word-address generator: beat k of a burst starting at word 'start'
// within the 16-byte line at 'base'.
module ahb_wrap_addr #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [1:0]        start,
  input  logic [1:0]        k,
  output logic [ADDR_W-1:0] addr
);

  logic [1:0] word_idx;

  // Two-bit add wraps naturally at the 4-word line boundary.
  assign word_idx = start + k;
  assign addr     = {base[ADDR_W-1:4], word_idx, 2'b00};

endmodule

// File: rtl/ahb_line_fetch.sv
// I-cache miss line fetcher: one WRAP4 critical-word-first read burst per miss,
// early critical word return, full line assembly, ERROR abort.
//
// Handshake: miss_req is a level held by the requester; it is accepted only in
// IDLE, where miss_ack pulses for exactly that cycle. Every other output toward
// the cache (crit_valid, fill_valid, fill_err) is a single-cycle pulse with no
// backpressure; their data outputs hold until the next burst overwrites them.
module ahb_line_fetch
  import ahb_pkg::*;
#(
  parameter int LINE_WORDS = ahb_pkg::LINE_WORDS,
  parameter int ADDR_W     = ahb_pkg::ADDR_W,
  parameter int DATA_W     = ahb_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         miss_req,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         miss_ack,
  output logic                         crit_valid,
  output logic [DATA_W-1:0]            crit_data,
  output logic                         fill_valid,
  output logic                         fill_err,
  output logic [ADDR_W-1:0]            fill_addr,
  output logic [LINE_WORDS*DATA_W-1:0] fill_data,
  output logic [ADDR_W-1:0]            haddr,
  output logic [1:0]                   htrans,
  output logic [2:0]                   hburst,
  output logic [2:0]                   hsize,
  output logic                         hwrite,
  input  logic [DATA_W-1:0]            hrdata,
  input  logic                         hready,
  input  logic                         hresp,
  output fetch_state_e                 dbg_state
);

  fetch_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]            base_q, base_d;
  logic [1:0]                   start_q, start_d;
  logic [1:0]                   addr_cnt_q, addr_cnt_d;
  logic [1:0]                   data_cnt_q, data_cnt_d;
  logic                         cancel_q, cancel_d;
  logic [LINE_WORDS*DATA_W-1:0] line_q, line_d;
  logic [DATA_W-1:0]            crit_data_q, crit_data_d;
  logic                         crit_valid_q, crit_valid_d;

  logic                         capture;
  logic [1:0]                   cap_idx;
  logic [ADDR_W-1:0]            beat_addr;

  // addr_cnt is cleared on accept, so it also serves as k=0 for the ADDR beat.
  ahb_wrap_addr #(.ADDR_W(ADDR_W)) u_wrap (
    .base  (base_q),
    .start (start_q),
    .k     (addr_cnt_q),
    .addr  (beat_addr)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      start_q      <= '0;
      addr_cnt_q   <= '0;
      data_cnt_q   <= '0;
      cancel_q     <= 1'b0;
      line_q       <= '0;
      crit_data_q  <= '0;
      crit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      start_q      <= start_d;
      addr_cnt_q   <= addr_cnt_d;
      data_cnt_q   <= data_cnt_d;
      cancel_q     <= cancel_d;
      line_q       <= line_d;
      crit_data_q  <= crit_data_d;
      crit_valid_q <= crit_valid_d;
    end
  end

  // Next state, beat counters and data capture into the line buffer.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    start_d      = start_q;
    addr_cnt_d   = addr_cnt_q;
    data_cnt_d   = data_cnt_q;
    cancel_d     = cancel_q;
    line_d       = line_q;
    crit_data_d  = crit_data_q;
    crit_valid_d = 1'b0;
    capture      = 1'b0;
    cap_idx      = start_q + data_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          state_d    = ST_ADDR;
          base_d     = {miss_addr[ADDR_W-1:4], 4'b0000};
          start_d    = miss_addr[3:2];
          addr_cnt_d = '0;
          data_cnt_d = '0;
          cancel_d   = 1'b0;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          addr_cnt_d = 2'd1;
          state_d    = ST_BURST;
        end
      end
      ST_BURST, ST_DRAIN: begin
        if (hresp) begin
          // First ERROR cycle cancels the rest; the second one ends the burst.
          if (!hready) cancel_d = 1'b1;
          else         state_d  = ST_ERR;
        end else if (hready) begin
          capture    = 1'b1;
          data_cnt_d = data_cnt_q + 2'd1;
          if (state_q == ST_BURST) begin
            addr_cnt_d = addr_cnt_q + 2'd1;
            if (addr_cnt_q == 2'd3) state_d = ST_DRAIN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        state_d  = ST_IDLE;
        cancel_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (cap_idx == i[1:0]) line_d[i*DATA_W +: DATA_W] = hrdata;
      end
      if (data_cnt_q == 2'd0) begin
        crit_data_d  = hrdata;
        crit_valid_d = 1'b1;
      end
    end
  end

  // Bus and cache-side outputs decoded from the current state.
  always_comb begin
    miss_ack   = rstn && (state_q == ST_IDLE) && miss_req;
    htrans     = HTRANS_IDLE;
    haddr      = '0;
    case (state_q)
      ST_ADDR: begin
        htrans = HTRANS_NONSEQ;
        haddr  = beat_addr;
      end
      ST_BURST: begin
        if (!cancel_q) begin
          htrans = HTRANS_SEQ;
          haddr  = beat_addr;
        end
      end
      default: ;
    endcase
    hburst     = (htrans == HTRANS_IDLE) ? HBURST_SINGLE : HBURST_WRAP4;
    hsize      = HSIZE_WORD;
    hwrite     = 1'b0;
    fill_valid = (state_q == ST_DONE);
    fill_err   = (state_q == ST_ERR);
    fill_addr  = base_q;
    fill_data  = line_q;
    crit_valid = crit_valid_q;
    crit_data  = crit_data_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_ahb_line_fetch.sv
// Directed and randomized bench for ahb_line_fetch acting as the AHB slave.
module tb_ahb_line_fetch;
  import ahb_pkg::*;

  logic          clk;
  logic          rstn;
  logic          miss_req;
  logic [31:0]   miss_addr;
  logic          miss_ack;
  logic          crit_valid;
  logic [31:0]   crit_data;
  logic          fill_valid;
  logic          fill_err;
  logic [31:0]   fill_addr;
  logic [127:0]  fill_data;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [31:0]   hrdata;
  logic          hready;
  logic          hresp;
  fetch_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ahb_line_fetch dut (
    .clk(clk), .rstn(rstn), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .crit_valid(crit_valid), .crit_data(crit_data),
    .fill_valid(fill_valid), .fill_err(fill_err), .fill_addr(fill_addr),
    .fill_data(fill_data), .haddr(haddr), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .hrdata(hrdata), .hready(hready),
    .hresp(hresp), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".miss_ack"},   miss_ack, 0);
    check({tag, ".crit_valid"}, crit_valid, 0);
    check({tag, ".crit_data"},  crit_data, 0);
    check({tag, ".fill_valid"}, fill_valid, 0);
    check({tag, ".fill_err"},   fill_err, 0);
    check({tag, ".fill_addr"},  fill_addr, 0);
    check({tag, ".fill_data"},  fill_data, 0);
    check({tag, ".haddr"},      haddr, 0);
    check({tag, ".htrans"},     htrans, 0);
    check({tag, ".hburst"},     hburst, 0);
    check({tag, ".hsize"},      hsize, 2);
    check({tag, ".hwrite"},     hwrite, 0);
    check({tag, ".state"},      dbg_state, ST_IDLE);
  endtask

  // One miss: the bench plays the slave with per-beat wait counts; err_beat 0..3
  // answers that beat with a two-cycle ERROR, 4 means no error.
  task automatic run_burst(input logic [31:0] addr, input int w0, input int w1,
                           input int w2, input int w3, input int err_beat,
                           input bit hold);
    int          w[4];
    logic [31:0] dat[4];
    logic [31:0] ba[4];
    logic [31:0] base;
    logic [127:0] exp_line;
    logic [1:0]  e_tr[64];
    logic [31:0] e_ad[64];
    bit          d_rdy[64], d_resp[64], e_crit[64], e_fill[64], e_err[64];
    logic [31:0] d_dat[64];
    int          t, last, st, nk;
    bit          done;
    logic [1:0]  ntr;
    logic [31:0] nad;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    base = addr & 32'hFFFF_FFF0;
    st   = int'(addr[3:2]);
    for (int k = 0; k < 4; k++) begin
      dat[k] = $urandom;
      ba[k]  = base + 32'(((st + k) % 4) * 4);
    end
    for (int c = 0; c < 64; c++) begin
      e_tr[c] = 2'd0; e_ad[c] = '0; d_rdy[c] = 1'b1; d_resp[c] = 1'b0;
      d_dat[c] = $urandom; e_crit[c] = 1'b0; e_fill[c] = 1'b0; e_err[c] = 1'b0;
    end
    e_tr[1] = 2'd2; e_ad[1] = ba[0];
    t = 2; last = 0; done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!done) begin
        nk  = (k < 3) ? k + 1 : 3;
        ntr = (k < 3) ? 2'd3 : 2'd0;
        nad = ba[nk];
        if (k == err_beat) begin
          e_tr[t] = ntr; e_ad[t] = nad; d_rdy[t] = 1'b0; d_resp[t] = 1'b1;
          e_tr[t+1] = 2'd0; d_rdy[t+1] = 1'b1; d_resp[t+1] = 1'b1;
          e_err[t+2] = 1'b1;
          last = t + 2;
          done = 1'b1;
        end else begin
          for (int i = 0; i <= w[k]; i++) begin
            e_tr[t+i] = ntr; e_ad[t+i] = nad; d_rdy[t+i] = (i == w[k]);
          end
          d_dat[t+w[k]] = dat[k];
          if (k == 0) e_crit[t+w[k]+1] = 1'b1;
          t = t + w[k] + 1;
        end
      end
    end
    if (!done) begin
      e_fill[t] = 1'b1;
      last = t;
      // Expected line in word-index order: word i holds the beat whose address is i.
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++)
          if (int'(ba[k][3:2]) == i) exp_q.push_back(dat[k]);
    end

    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      miss_req  = (c == 0) || hold;
      miss_addr = addr;
      hready    = d_rdy[c];
      hresp     = d_resp[c];
      hrdata    = d_dat[c];
      #1;
      check($sformatf("c%0d.miss_ack", c), miss_ack, (c == 0));
      check($sformatf("c%0d.htrans", c), htrans, e_tr[c]);
      if (e_tr[c] != 2'd0) begin
        check($sformatf("c%0d.haddr", c), haddr, e_ad[c]);
        check($sformatf("c%0d.hburst", c), hburst, 3'd2);
      end
      check($sformatf("c%0d.crit_valid", c), crit_valid, e_crit[c]);
      if (e_crit[c]) check("crit_data", crit_data, dat[0]);
      check($sformatf("c%0d.fill_valid", c), fill_valid, e_fill[c]);
      check($sformatf("c%0d.fill_err", c), fill_err, e_err[c]);
      if (e_fill[c]) begin
        check("fill_addr", fill_addr, base);
        exp_line = '0;
        for (int i = 0; i < 4; i++) exp_line[32*i +: 32] = exp_q.pop_front();
        check("fill_data", fill_data, exp_line);
      end
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      miss_req = 1'b0; hready = 1'b1; hresp = 1'b0;
      #1;
      check("post.miss_ack", miss_ack, 0);
      check("post.htrans", htrans, 0);
      check("post.fill_valid", fill_valid, 0);
      check("post.fill_err", fill_err, 0);
    end
  endtask

  initial begin
    rstn = 1'b0; miss_req = 1'b0; miss_addr = '0; hrdata = '0;
    hready = 1'b1; hresp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // Zero-wait burst from word 2, then two wait states on beat 2.
    run_burst(32'h0000_1008, 0, 0, 0, 0, 4, 1'b0);
    run_burst(32'h2000_0000, 0, 0, 2, 0, 4, 1'b0);
    // ERROR on beat 1 after the critical word.
    run_burst($urandom, 0, 0, 0, 0, 1, 1'b0);
    // Request held high across back-to-back fills.
    run_burst($urandom, 0, 0, 0, 0, 4, 1'b1);
    run_burst($urandom, 0, 1, 0, 0, 4, 1'b1);
    run_burst($urandom, 1, 0, 0, 0, 4, 1'b0);
    // Randomized waits, start words and occasional errors.
    for (int n = 0; n < 24; n++) begin
      run_burst($urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 9) < 7) ? 4 : int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset asserted in cycle 3 of a burst.
    @(posedge clk); #1; miss_req = 1'b1; miss_addr = $urandom; hready = 1'b1; hrdata = $urandom;
    @(posedge clk); #1; miss_req = 1'b0; hrdata = $urandom;
    @(posedge clk); #1; hrdata = $urandom;
    @(posedge clk); #1; rstn = 1'b0; hrdata = $urandom;
    @(posedge clk); #1; rstn = 1'b1;
    #1;
    check_all_zero("midreset");
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      check("midreset.fill_valid", fill_valid, 0);
      check("midreset.fill_err", fill_err, 0);
      check("midreset.htrans", htrans, 0);
    end
    run_burst($urandom, 0, 0, 0, 0, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
